hdmi_source_scheduler: RTL and testbench
========================================

Name: hdmi_source_scheduler

Overview:
- Feeds the red/green/blue inputs of the HDMI transceiver. Picks each pixel from one of three sources: the built-in quadrant test pattern, stereo source A (left camera) or stereo source B (right camera).
- Drives the pixel read strobes of the two camera sources.
- Accepts display-mode change requests through a valid/ready handshake. A mode change takes effect only at a frame boundary, so a frame never shows mixed modes.
- Runs in the pixel clock domain, next to the transceiver, and uses the transceiver's cntX/cntY raster position.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- SPLIT_X, 320, first column taken from source B in side-by-side mode; also the vertical quadrant edge of the test pattern.
- SPLIT_Y, 240, horizontal quadrant edge of the test pattern.
- CNT_W, 26, width of the raster counters.

Ports:
- pixclk  in  1  pixel clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- cntX  in  CNT_W  current column from the transceiver
- cntY  in  CNT_W  current line from the transceiver
- mode_req  in  2  requested mode: 0 test pattern, 1 source A, 2 source B, 3 side-by-side
- mode_req_valid  in  1  mode request valid
- mode_req_ready  out  1  scheduler can accept a request
- mode_cur  out  2  mode in force for the current frame
- frame_start  out  1  one-cycle pulse at the frame boundary
- src_a_data  in  24  source A pixel, {R,G,B}
- src_a_valid  in  1  source A pixel available
- src_a_rd  out  1  source A pixel consumed this cycle
- src_b_data  in  24  source B pixel, {R,G,B}
- src_b_valid  in  1  source B pixel available
- src_b_rd  out  1  source B pixel consumed this cycle
- underflow_clr  in  1  clears underflow_cnt
- underflow_cnt  out  16  saturating count of starved pixels
- red  out  8  pixel red to the transceiver
- green  out  8  pixel green to the transceiver
- blue  out  8  pixel blue to the transceiver

Behaviour:
- Clock and reset: single clock, pixclk. Reset is asynchronous and active-low (rst_n).
- Reset values: red/green/blue=0, mode_cur=0, mode_req_ready=1, frame_start=0, src_a_rd=0, src_b_rd=0, underflow_cnt=0, FSM in IDLE, pending mode register cleared.
- Reset asserted mid-frame or with a request pending: the pending request is discarded and outputs return immediately to their reset values.
- active = (cntX < H_ACTIVE) && (cntY < V_ACTIVE). All comparisons are unsigned and CNT_W wide.
- Frame boundary: frame_start is registered. It pulses for one cycle on the first cycle that cntX==0 && cntY==0, after a cycle where that was not true. It never pulses twice for one boundary.
- Mode FSM, two states:
  - IDLE: mode_req_ready=1. When mode_req_valid is high, latch mode_req into pending and move to PENDING.
  - PENDING: mode_req_ready=0 and requests are ignored. On the frame-boundary detect cycle, mode_cur <= pending and the FSM returns to IDLE. mode_req_ready is 1 again on the cycle after the switch.
  - A request accepted in the same cycle as the frame-boundary detect is applied at the next boundary, not the current one.
- Source select per pixel:
  - mode 0 selects the pattern.
  - mode 1 selects A.
  - mode 2 selects B.
  - mode 3 selects A when cntX < SPLIT_X, otherwise B.
- Read strobes (combinational): src_X_rd = active && (selected source is X) && src_X_valid. At most one strobe is high per cycle.
- Output pixel: registered, latency 1 cycle from the cntX/cntY sample.
  - Not active: output 000000.
  - Pattern, cntY < SPLIT_Y: FF0000 when cntX < SPLIT_X, otherwise 00FF00.
  - Pattern, cntY >= SPLIT_Y: 0000FF when cntX < SPLIT_X, otherwise FFFFFF.
  - Camera source with valid high: output its data.
  - Camera source with valid low: output FF00FF (magenta) and increment underflow_cnt.
- underflow_cnt saturates at FFFF. underflow_clr has priority over an increment in the same cycle.
- Blanking cycles never assert a read strobe and never count as underflow.

Test Plan:
- Hold rst_n=0, then release -> red/green/blue=0, mode_cur=0, mode_req_ready=1. Run one frame in mode 0 -> pixel (10,10)=FF0000, (400,10)=00FF00, (10,300)=0000FF, (400,300)=FFFFFF. Each appears one cycle after the matching cntX/cntY, and (700,10)=000000.
- Request mode 1 at cntY=100 -> mode_req_ready drops the next cycle and mode_cur stays 0 until (0,0). frame_start then pulses once, mode_cur=1, and mode_req_ready=1 the cycle after. A second request during PENDING is ignored.
- Mode 3 with both sources always valid -> src_a_rd high for cntX 0..319 and src_b_rd high for cntX 320..639 on each active line. Exactly 153600 strobes per source per frame, and none during blanking.
- Mode 1 with src_a_valid low for 5 active pixels -> those 5 pixels show FF00FF and underflow_cnt=5. Pulse underflow_clr together with a sixth starved pixel -> count=0.
- Raise mode_req_valid exactly on the frame-boundary detect cycle -> the request is accepted, and the switch happens at the following frame boundary.
- Assert rst_n=0 mid-line while PENDING -> outputs clear immediately and the pending mode is lost. After release, mode_cur=0 through the next frame boundary.

Source files
------------

// File: rtl/hdmi_source_scheduler.sv
// Pixel source scheduler for the HDMI transceiver: picks test pattern, camera A,
// camera B or side-by-side per pixel, and switches display mode only at frame boundaries.
module hdmi_source_scheduler #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SPLIT_X  = 320,
  parameter int unsigned SPLIT_Y  = 240,
  parameter int unsigned CNT_W    = 26
) (
  input  logic             pixclk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cntX,
  input  logic [CNT_W-1:0] cntY,
  input  logic [1:0]       mode_req,
  input  logic             mode_req_valid,
  output logic             mode_req_ready,
  output logic [1:0]       mode_cur,
  output logic             frame_start,
  input  logic [23:0]      src_a_data,
  input  logic             src_a_valid,
  output logic             src_a_rd,
  input  logic [23:0]      src_b_data,
  input  logic             src_b_valid,
  output logic             src_b_rd,
  input  logic             underflow_clr,
  output logic [15:0]      underflow_cnt,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue,
  output logic             dbg_pending
);

  localparam logic [CNT_W-1:0] H_LIM  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LIM  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] X_EDGE = CNT_W'(SPLIT_X);
  localparam logic [CNT_W-1:0] Y_EDGE = CNT_W'(SPLIT_Y);
  localparam logic [23:0]      MAGENTA = 24'hFF00FF;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  mode_q, mode_d;
  logic        origin_prev_q;
  logic        fs_q;
  logic [23:0] pix_q, pix_d;
  logic [15:0] ucnt_q, ucnt_d;

  logic        at_origin, boundary, active, left_half;
  logic [1:0]  mode_eff;
  logic        sel_a, sel_b, starved;
  logic [23:0] pattern;

  assign at_origin = (cntX == '0) && (cntY == '0);
  assign boundary  = at_origin && !origin_prev_q;
  assign active    = (cntX < H_LIM) && (cntY < V_LIM);
  assign left_half = (cntX < X_EDGE);

  // Handshake: a request transfers on any cycle with mode_req_valid && mode_req_ready;
  // ready stays low while the accepted mode waits for the next frame boundary.
  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    mode_d         = mode_q;
    mode_req_ready = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (mode_req_valid) begin
          pend_d  = mode_req;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (boundary) begin
          mode_d  = pend_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The first pixel of a frame already uses the mode that takes over at this boundary.
  assign mode_eff = ((state_q == PENDING) && boundary) ? pend_q : mode_q;

  always_comb begin
    sel_a = (mode_eff == 2'd1) || ((mode_eff == 2'd3) && left_half);
    sel_b = (mode_eff == 2'd2) || ((mode_eff == 2'd3) && !left_half);
  end

  assign src_a_rd = active && sel_a && src_a_valid;
  assign src_b_rd = active && sel_b && src_b_valid;
  assign starved  = active && ((sel_a && !src_a_valid) || (sel_b && !src_b_valid));

  always_comb begin
    if (cntY < Y_EDGE) pattern = left_half ? 24'hFF0000 : 24'h00FF00;
    else               pattern = left_half ? 24'h0000FF : 24'hFFFFFF;
  end

  always_comb begin
    pix_d = '0;
    if (active) begin
      if (sel_a)      pix_d = src_a_valid ? src_a_data : MAGENTA;
      else if (sel_b) pix_d = src_b_valid ? src_b_data : MAGENTA;
      else            pix_d = pattern;
    end
  end

  always_comb begin
    ucnt_d = ucnt_q;
    if (underflow_clr)                      ucnt_d = '0;
    else if (starved && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      mode_q        <= '0;
      origin_prev_q <= 1'b0;
      fs_q          <= 1'b0;
      pix_q         <= '0;
      ucnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      mode_q        <= mode_d;
      origin_prev_q <= at_origin;
      fs_q          <= boundary;
      pix_q         <= pix_d;
      ucnt_q        <= ucnt_d;
    end
  end

  assign mode_cur      = mode_q;
  assign frame_start   = fs_q;
  assign underflow_cnt = ucnt_q;
  assign red           = pix_q[23:16];
  assign green         = pix_q[15:8];
  assign blue          = pix_q[7:0];
  assign dbg_pending   = (state_q == PENDING);

endmodule

// File: tb/tb_hdmi_source_scheduler.sv
// Bench for hdmi_source_scheduler on a reduced 16x8 raster (20x10 total) so whole
// frames fit in a short run; expected responses are queued and checked by a monitor.
module tb_hdmi_source_scheduler;

  localparam int HA = 16, VA = 8, SX = 6, SY = 3, CW = 26;
  localparam int HT = 20, VT = 10;
  localparam int EW = 44;

  logic          pixclk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] cntX, cntY;
  logic [1:0]    mode_req;
  logic          mode_req_valid, mode_req_ready;
  logic [1:0]    mode_cur;
  logic          frame_start;
  logic [23:0]   src_a_data, src_b_data;
  logic          src_a_valid, src_b_valid, src_a_rd, src_b_rd;
  logic          underflow_clr;
  logic [15:0]   underflow_cnt;
  logic [7:0]    red, green, blue;
  logic          dbg_pending;

  hdmi_source_scheduler #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .SPLIT_X(SX), .SPLIT_Y(SY), .CNT_W(CW)
  ) dut (
    .pixclk(pixclk), .rst_n(rst_n), .cntX(cntX), .cntY(cntY),
    .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
    .mode_cur(mode_cur), .frame_start(frame_start),
    .src_a_data(src_a_data), .src_a_valid(src_a_valid), .src_a_rd(src_a_rd),
    .src_b_data(src_b_data), .src_b_valid(src_b_valid), .src_b_rd(src_b_rd),
    .underflow_clr(underflow_clr), .underflow_cnt(underflow_cnt),
    .red(red), .green(green), .blue(blue), .dbg_pending(dbg_pending)
  );

  // clock / cycle counter
  always #20 pixclk = ~pixclk;
  int cyc = 0;
  always @(posedge pixclk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int cnt_a = 0, cnt_b = 0;
  logic cnt_en = 1'b0;

  logic [EW-1:0] exp_q[$];
  int            exp_due_q[$];
  logic [1:0]    str_q[$];
  int            str_due_q[$];

  // reference state
  logic [1:0]  m_mode, m_pend;
  logic        m_pending, m_prev;
  logic [15:0] m_ucnt;

  // stimulus state
  logic [CW-1:0] cx, cy;
  logic [1:0]    g_req;
  logic          g_req_v, g_av, g_bv, g_clr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = 2'd0; m_pend = 2'd0; m_pending = 1'b0; m_prev = 1'b0; m_ucnt = 16'd0;
  endtask

  function automatic logic [23:0] pattern_px(input logic [CW-1:0] x, input logic [CW-1:0] y);
    if (y < SY) return (x < SX) ? 24'hFF0000 : 24'h00FF00;
    else        return (x < SX) ? 24'h0000FF : 24'hFFFFFF;
  endfunction

  // monitor / scoreboard
  logic [EW-1:0] e;
  logic [1:0]    s;
  always @(negedge pixclk) begin
    while (str_due_q.size() > 0 && str_due_q[0] <= cyc) begin
      s = str_q.pop_front();
      void'(str_due_q.pop_front());
      chk("src_a_rd", 32'(src_a_rd), 32'(s[1]));
      chk("src_b_rd", 32'(src_b_rd), 32'(s[0]));
    end
    while (exp_due_q.size() > 0 && exp_due_q[0] <= cyc) begin
      e = exp_q.pop_front();
      void'(exp_due_q.pop_front());
      chk("pixel", 32'({red, green, blue}), 32'(e[43:20]));
      chk("mode_cur", 32'(mode_cur), 32'(e[19:18]));
      chk("frame_start", 32'(frame_start), 32'(e[17]));
      chk("mode_req_ready", 32'(mode_req_ready), 32'(e[16]));
      chk("underflow_cnt", 32'(underflow_cnt), 32'(e[15:0]));
    end
    if (cnt_en) begin
      if (src_a_rd) cnt_a++;
      if (src_b_rd) cnt_b++;
    end
  end

  // driver: apply one raster position, queue expectations, advance one clock
  task automatic tick();
    logic origin, bnd, act, sa, sb, ra, rb, starve;
    logic [1:0]  eff;
    logic [23:0] ad, bd, px;
    ad = {8'h11, cx[7:0], cy[7:0]};
    bd = {8'h22, cx[7:0], cy[7:0]};
    cntX = cx; cntY = cy;
    mode_req = g_req; mode_req_valid = g_req_v;
    src_a_data = ad; src_a_valid = g_av;
    src_b_data = bd; src_b_valid = g_bv;
    underflow_clr = g_clr;
    origin = (cx == 0) && (cy == 0);
    bnd    = origin && !m_prev;
    eff    = (bnd && m_pending) ? m_pend : m_mode;
    act    = (cx < HA) && (cy < VA);
    sa     = (eff == 2'd1) || (eff == 2'd3 && cx < SX);
    sb     = (eff == 2'd2) || (eff == 2'd3 && cx >= SX);
    ra     = act && sa && g_av;
    rb     = act && sb && g_bv;
    starve = act && ((sa && !g_av) || (sb && !g_bv));
    if (!act)    px = 24'h000000;
    else if (sa) px = g_av ? ad : 24'hFF00FF;
    else if (sb) px = g_bv ? bd : 24'hFF00FF;
    else         px = pattern_px(cx, cy);
    if (m_pending) begin
      if (bnd) begin m_mode = m_pend; m_pending = 1'b0; end
    end else if (g_req_v) begin
      m_pend = g_req; m_pending = 1'b1;
    end
    if (g_clr) m_ucnt = 16'd0;
    else if (starve && m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
    m_prev = origin;
    str_q.push_back({ra, rb});
    str_due_q.push_back(cyc);
    exp_q.push_back({px, m_mode, bnd, !m_pending, m_ucnt});
    exp_due_q.push_back(cyc + 1);
    @(posedge pixclk); #1;
    cx = cx + 1;
    if (cx == HT) begin
      cx = 0;
      cy = cy + 1;
      if (cy == VT) cy = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_to(input int x, input int y);
    int k = 0;
    while (!(cx == x && cy == y) && k < HT * VT) begin
      tick();
      k++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rgb"}, 32'({red, green, blue}), 0);
    chk({tag, "_mode_cur"}, 32'(mode_cur), 0);
    chk({tag, "_ready"}, 32'(mode_req_ready), 1);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_ucnt"}, 32'(underflow_cnt), 0);
    chk({tag, "_rd_a"}, 32'(src_a_rd), 0);
    chk({tag, "_rd_b"}, 32'(src_b_rd), 0);
  endtask

  logic [CW-1:0] px0, py0;

  initial begin
    rst_n = 1'b0;
    g_req = 2'd0; g_req_v = 1'b0; g_av = 1'b1; g_bv = 1'b1; g_clr = 1'b0;
    cntX = 5; cntY = 1; mode_req = 2'd0; mode_req_valid = 1'b0;
    src_a_data = 24'h123456; src_a_valid = 1'b1;
    src_b_data = 24'h654321; src_b_valid = 1'b1; underflow_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge pixclk);
    #1;
    check_reset_outputs("reset");

    // mode 0 test pattern frame
    rst_n = 1'b1;
    cx = 0; cy = 0;
    run(HT * VT);

    // mode 1 request mid-frame; a second request while pending must be ignored
    run_to(0, 2);
    g_req = 2'd1; g_req_v = 1'b1;
    tick();
    chk("req1_ready_drop", 32'(mode_req_ready), 0);
    chk("req1_mode_hold", 32'(mode_cur), 0);
    g_req = 2'd2;
    tick();
    g_req_v = 1'b0;
    run_to(0, 0);
    tick();
    chk("switch1_mode", 32'(mode_cur), 1);
    chk("switch1_fs", 32'(frame_start), 1);
    chk("switch1_ready", 32'(mode_req_ready), 1);
    tick();
    chk("switch1_fs_once", 32'(frame_start), 0);

    // camera A starved for 5 active pixels, then clear against a sixth starved pixel
    while (!(cx == 0 && cy == 3)) begin
      px0 = cx; py0 = cy;
      g_av  = !((cy == 1 && cx >= 2 && cx <= 6) || cx >= HA || (cy == 2 && cx == 3));
      g_clr = (cy == 2 && cx == 3);
      tick();
      if (py0 == 1 && px0 == HT - 1) chk("ucnt_after_5", 32'(underflow_cnt), 5);
      if (py0 == 2 && px0 == 3)      chk("ucnt_cleared", 32'(underflow_cnt), 0);
    end
    g_av = 1'b1; g_clr = 1'b0;

    // side-by-side strobe totals over one full frame
    g_req = 2'd3; g_req_v = 1'b1;
    tick();
    g_req_v = 1'b0;
    run_to(0, 0);
    cnt_a = 0; cnt_b = 0; cnt_en = 1'b1;
    run(HT * VT);
    cnt_en = 1'b0;
    chk("sbs_strobes_a", 32'(cnt_a), SX * VA);
    chk("sbs_strobes_b", 32'(cnt_b), (HA - SX) * VA);

    // request raised exactly on the boundary detect cycle
    g_req = 2'd2; g_req_v = 1'b1;
    tick();
    g_req_v = 1'b0;
    chk("bnd_req_fs", 32'(frame_start), 1);
    chk("bnd_req_not_now", 32'(mode_cur), 3);
    chk("bnd_req_accepted", 32'(mode_req_ready), 0);
    run_to(0, 0);
    tick();
    chk("bnd_req_next_frame", 32'(mode_cur), 2);

    // reset mid-line while a request is pending
    run_to(0, 3);
    g_req = 2'd1; g_req_v = 1'b1;
    tick();
    g_req_v = 1'b0;
    run_to(8, 5);
    tick();
    chk("pre_reset_pixel", 32'({red, green, blue}), 32'h220805);
    exp_q.delete(); exp_due_q.delete();
    str_q.delete(); str_due_q.delete();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge pixclk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_to(0, 0);
    tick();
    chk("post_reset_fs", 32'(frame_start), 1);
    chk("post_reset_mode", 32'(mode_cur), 0);
    run(30);

    @(negedge pixclk);
    #1;
    chk("queues_drained", 32'(exp_q.size() + str_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
